// File: rtl/mem_arbiter_if.sv
// Bus bundle between fetch, load/store path, arbiter and the memory macro.
// The slave modport is the arbiter's view; master is the surrounding system.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt;
    logic        if_rvalid;
    logic [31:0] if_rdata;
    logic        d_req;
    logic        d_we;
    logic [3:0]  d_be;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_ready;
    logic        mem_en;
    logic [3:0]  mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_be, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        input  mem_ready, mem_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_be, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        output mem_ready, mem_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data-priority grants with fetch anti-starvation,
// and one-cycle read-data steering back to the requester that issued the read.
module mem_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DATA = 2'd2
    } own_e;

    localparam logic [3:0] LP_MAX = 4'(STARVE_MAX);

    own_e       r_rd_own;
    own_e       w_rd_own_nxt;
    logic [3:0] r_starve_cnt;
    logic [3:0] w_starve_nxt;
    logic       w_rdy;
    logic       w_fetch_pri;
    logic       w_if_gnt;
    logic       w_d_gnt;

    // Grants are gated by reset so every output reads 0 while it is held low.
    assign w_rdy       = reset & bus.mem_ready;
    assign w_fetch_pri = (r_starve_cnt == LP_MAX);
    assign w_if_gnt    = w_rdy & bus.if_req & (~bus.d_req | w_fetch_pri);
    assign w_d_gnt     = w_rdy & bus.d_req & ~w_if_gnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_own     <= OWN_NONE;
            r_starve_cnt <= '0;
        end else begin
            r_rd_own     <= w_rd_own_nxt;
            r_starve_cnt <= w_starve_nxt;
        end
    end

    always_comb begin
        w_rd_own_nxt = OWN_NONE;
        unique case (1'b1)
            w_if_gnt:             w_rd_own_nxt = OWN_IF;
            w_d_gnt & ~bus.d_we:  w_rd_own_nxt = OWN_DATA;
            default:              w_rd_own_nxt = OWN_NONE;
        endcase
    end

    always_comb begin
        w_starve_nxt = r_starve_cnt;
        if (!bus.if_req || w_if_gnt) begin
            w_starve_nxt = '0;
        end else if (bus.mem_ready && r_starve_cnt < LP_MAX) begin
            w_starve_nxt = r_starve_cnt + 4'd1;
        end
    end

    always_comb begin
        bus.if_gnt    = w_if_gnt;
        bus.d_gnt     = w_d_gnt;
        bus.mem_en    = w_if_gnt | w_d_gnt;
        bus.mem_we    = '0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.if_rvalid = (r_rd_own == OWN_IF);
        bus.d_rvalid  = (r_rd_own == OWN_DATA);
        bus.if_rdata  = '0;
        bus.d_rdata   = '0;
        unique case (1'b1)
            w_if_gnt: begin
                bus.mem_addr = bus.if_addr;
            end
            w_d_gnt: begin
                bus.mem_addr  = bus.d_addr;
                bus.mem_wdata = bus.d_wdata;
                bus.mem_we    = bus.d_we ? bus.d_be : 4'b0000;
            end
            default: ;
        endcase
        if (bus.if_rvalid) bus.if_rdata = bus.mem_rdata;
        if (bus.d_rvalid)  bus.d_rdata  = bus.mem_rdata;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: grants, starvation cap, stores,
// mem_ready stalls, back-to-back steering and reset behaviour.
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    logic r_if_pend;
    logic r_d_pend;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_MAX(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requesters must hold req until granted.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_pend <= 1'b0;
            r_d_pend  <= 1'b0;
        end else begin
            assert (!(r_if_pend && !bus.if_req))
                else $error("FAIL if_req dropped before if_gnt");
            assert (!(r_d_pend && !bus.d_req))
                else $error("FAIL d_req dropped before d_gnt");
            r_if_pend <= bus.if_req & ~bus.if_gnt;
            r_d_pend  <= bus.d_req & ~bus.d_gnt;
        end
    end

    task automatic idle_inputs();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_be      = '0;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        logic [136:0] outs;
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h40;
        #1;
        n_cmp++;
        if (bus.d_gnt !== 1'b1) begin
            n_err++;
            $display("FAIL reset_pre_gnt got=%b exp=1", bus.d_gnt);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.d_req  = 1'b1;
        bus.if_req = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
        #1;
        outs = {bus.if_gnt, bus.if_rvalid, bus.if_rdata,
                bus.d_gnt, bus.d_rvalid, bus.d_rdata,
                bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata};
        n_cmp++;
        if (outs !== '0) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        n_cmp++;
        if (dut.r_starve_cnt !== 4'd0) begin
            n_err++;
            $display("FAIL reset_starve got=%0d exp=0", dut.r_starve_cnt);
        end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({bus.d_rvalid, bus.if_rvalid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_rvalid got=%b exp=00",
                     {bus.d_rvalid, bus.if_rvalid});
        end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        n_cmp++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr}
            !== {3'b101, 4'b0000, 32'h100}) begin
            n_err++;
            $display("FAIL fetch_gnt got=%b%b%b %b %h exp=101 0000 100",
                     bus.if_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                     bus.mem_addr);
        end
        @(negedge clk);
        bus.if_req    = 1'b0;
        bus.mem_rdata = 32'hDEADBEEF;
        #1;
        n_cmp++;
        if ({bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata}
            !== {1'b1, 32'hDEADBEEF, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL fetch_rdata got=%b %h %b %h exp=1 deadbeef 0 0",
                     bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata);
        end
        @(negedge clk);
        bus.mem_rdata = '0;
        #1;
        n_cmp++;
        if (bus.if_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL fetch_rvalid_clr got=%b exp=0", bus.if_rvalid);
        end
    endtask

    task automatic test_starve();
        logic [1:0] exp_g;
        @(negedge clk);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h300;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = 32'h400;
        for (int i = 0; i < 11; i++) begin
            exp_g = (i % 5 == 4) ? 2'b10 : 2'b01;
            #1;
            n_cmp++;
            if ({bus.if_gnt, bus.d_gnt} !== exp_g) begin
                n_err++;
                $display("FAIL starve_c%0d got=%b exp=%b", i,
                         {bus.if_gnt, bus.d_gnt}, exp_g);
            end
            if (i > 0) begin
                n_cmp++;
                if ({bus.if_rvalid, bus.d_rvalid} !==
                    (((i - 1) % 5 == 4) ? 2'b10 : 2'b01)) begin
                    n_err++;
                    $display("FAIL starve_rv_c%0d got=%b", i,
                             {bus.if_rvalid, bus.d_rvalid});
                end
            end
            @(negedge clk);
        end
        bus.d_req = 1'b0;
        #1;
        n_cmp++;
        if ({bus.if_gnt, bus.d_gnt, bus.mem_addr} !== {2'b10, 32'h300}) begin
            n_err++;
            $display("FAIL starve_tail got=%b %h exp=10 300",
                     {bus.if_gnt, bus.d_gnt}, bus.mem_addr);
        end
        @(negedge clk);
        bus.if_req = 1'b0;
    endtask

    task automatic test_store();
        @(negedge clk);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_be    = 4'b0100;
        bus.d_addr  = 32'h200;
        bus.d_wdata = 32'h00AB0000;
        #1;
        n_cmp++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}
            !== {2'b11, 4'b0100, 32'h200, 32'h00AB0000}) begin
            n_err++;
            $display("FAIL store_port got=%b %b %h %h", bus.mem_en,
                     bus.mem_we, bus.mem_addr, bus.mem_wdata);
        end
        @(negedge clk);
        bus.d_be      = 4'b0000;
        bus.d_addr    = 32'h204;
        bus.mem_rdata = 32'h12345678;
        #1;
        n_cmp++;
        if ({bus.d_rvalid, bus.if_rvalid, bus.d_rdata} !== 34'h0) begin
            n_err++;
            $display("FAIL store_no_rvalid got=%b%b %h", bus.d_rvalid,
                     bus.if_rvalid, bus.d_rdata);
        end
        n_cmp++;
        if ({bus.d_gnt, bus.mem_en, bus.mem_we} !== 6'b110000) begin
            n_err++;
            $display("FAIL store_be0 got=%b%b %b exp=11 0000", bus.d_gnt,
                     bus.mem_en, bus.mem_we);
        end
        @(negedge clk);
        idle_inputs();
        bus.mem_rdata = 32'h12345678;
        #1;
        n_cmp++;
        if ({bus.d_rvalid, bus.d_rdata} !== 33'h0) begin
            n_err++;
            $display("FAIL store_be0_rvalid got=%b %h exp=0 0",
                     bus.d_rvalid, bus.d_rdata);
        end
    endtask

    task automatic test_not_ready();
        @(negedge clk);
        idle_inputs();
        bus.if_req = 1'b1;
        bus.if_addr = 32'h500;
        bus.d_req  = 1'b1;
        bus.d_addr = 32'h600;
        repeat (3) @(negedge clk);
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 32'h55;
        #1;
        n_cmp++;
        if ({bus.d_rvalid, bus.d_rdata} !== {1'b1, 32'h55}) begin
            n_err++;
            $display("FAIL nrdy_inflight got=%b %h exp=1 55",
                     bus.d_rvalid, bus.d_rdata);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if ({bus.if_gnt, bus.d_gnt, bus.mem_en} !== 3'b000) begin
                n_err++;
                $display("FAIL nrdy_c%0d got=%b exp=000", i,
                         {bus.if_gnt, bus.d_gnt, bus.mem_en});
            end
            @(negedge clk);
        end
        n_cmp++;
        if (bus.d_rvalid !== 1'b0) begin
            n_err++;
            $display("FAIL nrdy_rvalid got=%b exp=0", bus.d_rvalid);
        end
        bus.mem_ready = 1'b1;
        #1;
        n_cmp++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b01) begin
            n_err++;
            $display("FAIL nrdy_resume got=%b exp=01",
                     {bus.if_gnt, bus.d_gnt});
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if ({bus.if_gnt, bus.d_gnt} !== 2'b10) begin
            n_err++;
            $display("FAIL nrdy_cap got=%b exp=10", {bus.if_gnt, bus.d_gnt});
        end
        @(negedge clk);
        bus.if_req = 1'b0;
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_addr = 32'h10;
        #1;
        n_cmp++;
        if ({bus.d_gnt, bus.mem_addr} !== {1'b1, 32'h10}) begin
            n_err++;
            $display("FAIL b2b_c0 got=%b %h exp=1 10", bus.d_gnt,
                     bus.mem_addr);
        end
        @(negedge clk);
        bus.d_req     = 1'b0;
        bus.if_req    = 1'b1;
        bus.if_addr   = 32'h20;
        bus.mem_rdata = 32'h11;
        #1;
        n_cmp++;
        if ({bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata}
            !== {1'b1, 32'h11, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL b2b_c1_rd got=%b %h %b %h exp=1 11 0 0",
                     bus.d_rvalid, bus.d_rdata, bus.if_rvalid, bus.if_rdata);
        end
        n_cmp++;
        if ({bus.if_gnt, bus.mem_addr} !== {1'b1, 32'h20}) begin
            n_err++;
            $display("FAIL b2b_c1_gnt got=%b %h exp=1 20", bus.if_gnt,
                     bus.mem_addr);
        end
        @(negedge clk);
        bus.if_req    = 1'b0;
        bus.mem_rdata = 32'h22;
        #1;
        n_cmp++;
        if ({bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata}
            !== {1'b1, 32'h22, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL b2b_c2_rd got=%b %h %b %h exp=1 22 0 0",
                     bus.if_rvalid, bus.if_rdata, bus.d_rvalid, bus.d_rdata);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        test_reset();
        test_fetch();
        test_starve();
        test_store();
        test_not_ready();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
